// File: rtl/button_conditioner_if.sv
`default_nettype none
//==============================================================================
// Module : button_conditioner_if
// Brief  : Key inputs, cursor enable, press pulses and cursor position.
// Rev    : 1.0 - initial release
//==============================================================================
interface button_conditioner_if;
    logic       btn_confirm_n;
    logic [3:0] btn_mov_n;
    logic       cursor_en;
    logic       confirm_pulse;
    logic [3:0] mov_pulse;
    logic [2:0] cur_x;
    logic [2:0] cur_y;

    modport master (
        output btn_confirm_n, btn_mov_n, cursor_en,
        input  confirm_pulse, mov_pulse, cur_x, cur_y
    );

    modport slave (
        input  btn_confirm_n, btn_mov_n, cursor_en,
        output confirm_pulse, mov_pulse, cur_x, cur_y
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
//==============================================================================
// Module : button_conditioner
// Brief  : Synchronise/debounce push-buttons, emit press and auto-repeat
//          pulses, and maintain the 5x5 selection cursor.
// Rev    : 1.0 - initial release
//==============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int REPEAT_DLY   = 12500000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int GRID         = 5
) (
    input  wire logic           clk,
    input  wire logic           reset,
    button_conditioner_if.slave bus
);
    localparam int c_nkeys   = 5;
    localparam int c_nmov    = 4;
    localparam int c_cnt_max = (DEBOUNCE_CYC > REPEAT_DLY) ?
                               ((DEBOUNCE_CYC > REPEAT_RATE) ? DEBOUNCE_CYC : REPEAT_RATE) :
                               ((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE);
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_db_last   = c_cnt_w'(DEBOUNCE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_dly_last  = c_cnt_w'(REPEAT_DLY - 1);
    localparam logic [c_cnt_w-1:0] c_rate_last = c_cnt_w'(REPEAT_RATE - 1);
    localparam logic [2:0]         c_cur_max   = 3'(GRID - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_press  = 2'd1;
    localparam logic [1:0] c_st_hold   = 2'd2;
    localparam logic [1:0] c_st_repeat = 2'd3;

    logic [c_nkeys-1:0] w_raw_n;
    logic [c_nkeys-1:0] w_pulse;

    // Bits [3:0] are the direction keys, bit 4 is confirm.
    assign w_raw_n = {bus.btn_confirm_n, bus.btn_mov_n};

    generate
        for (genvar gi = 0; gi < c_nkeys; gi++) begin : g_key
            localparam bit c_can_repeat = (gi < c_nmov);

            logic               r_sync1;
            logic               r_sync2;
            logic               r_stable;
            logic [c_cnt_w-1:0] r_db_cnt;
            logic [c_cnt_w-1:0] r_hold_cnt;
            logic [c_cnt_w-1:0] w_hold_cnt_nxt;
            logic [1:0]         r_state;
            logic [1:0]         w_state_nxt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_stable   <= 1'b0;
                    r_db_cnt   <= '0;
                    r_state    <= c_st_idle;
                    r_hold_cnt <= '0;
                end else begin
                    r_sync1 <= ~w_raw_n[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_stable) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_db_last) begin
                        r_stable <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                    r_state    <= w_state_nxt;
                    r_hold_cnt <= w_hold_cnt_nxt;
                end
            end

            // r_hold_cnt counts held cycles from the press pulse, then
            // becomes the repeat-period phase once in REPEAT.
            always_comb begin
                w_state_nxt    = r_state;
                w_hold_cnt_nxt = r_hold_cnt;
                case (r_state)
                    c_st_idle: begin
                        w_hold_cnt_nxt = '0;
                        if (r_stable) begin
                            w_state_nxt = c_st_press;
                        end
                    end
                    c_st_press: begin
                        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                        w_state_nxt    = r_stable ? c_st_hold : c_st_idle;
                    end
                    c_st_hold: begin
                        if (!r_stable) begin
                            w_state_nxt = c_st_idle;
                        end else if (c_can_repeat && (r_hold_cnt == c_dly_last)) begin
                            w_state_nxt    = c_st_repeat;
                            w_hold_cnt_nxt = '0;
                        end else if (r_hold_cnt != c_dly_last) begin
                            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                        end
                    end
                    c_st_repeat: begin
                        if (!r_stable) begin
                            w_state_nxt = c_st_idle;
                        end else if (r_hold_cnt == c_rate_last) begin
                            w_hold_cnt_nxt = '0;
                        end else begin
                            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt    = c_st_idle;
                        w_hold_cnt_nxt = '0;
                    end
                endcase
            end

            assign w_pulse[gi] = (r_state == c_st_press) ||
                                 ((r_state == c_st_repeat) && (r_hold_cnt == '0) && r_stable);
        end
    endgenerate

    logic       w_up;
    logic       w_dn;
    logic       w_lf;
    logic       w_rt;
    logic [2:0] r_x;
    logic [2:0] r_y;

    assign w_up = w_pulse[0];
    assign w_dn = w_pulse[1];
    assign w_lf = w_pulse[2];
    assign w_rt = w_pulse[3];

    // Opposing pulses on one axis cancel; the two axes step independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= 3'd0;
            r_y <= 3'd0;
        end else if (bus.cursor_en) begin
            if (w_up && !w_dn && (r_y != 3'd0)) begin
                r_y <= r_y - 3'd1;
            end else if (w_dn && !w_up && (r_y != c_cur_max)) begin
                r_y <= r_y + 3'd1;
            end
            if (w_lf && !w_rt && (r_x != 3'd0)) begin
                r_x <= r_x - 3'd1;
            end else if (w_rt && !w_lf && (r_x != c_cur_max)) begin
                r_x <= r_x + 3'd1;
            end
        end
    end

    assign bus.mov_pulse     = w_pulse[c_nmov-1:0];
    assign bus.confirm_pulse = w_pulse[c_nkeys-1];
    assign bus.cur_x         = r_x;
    assign bus.cur_y         = r_y;
endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
//==============================================================================
// Module : tb_button_conditioner
// Brief  : Self-checking bench for button_conditioner with a pulse scoreboard.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_button_conditioner;
    localparam int c_db   = 4;
    localparam int c_dly  = 20;
    localparam int c_rate = 8;
    localparam int c_grid = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYC (c_db),
        .REPEAT_DLY   (c_dly),
        .REPEAT_RATE  (c_rate),
        .GRID         (c_grid)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       conf;
        logic [3:0] mov;
        logic [2:0] x;
        logic [2:0] y;
    } ev_t;

    typedef struct {
        logic [3:0] mask;
        logic       conf;
        logic       en;
        logic [2:0] ex;
        logic [2:0] ey;
    } vec_t;

    ev_t        exp_q[$];
    logic       chk_cur = 1'b0;
    logic [2:0] exp_cx  = 3'd0;
    logic [2:0] exp_cy  = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_ev(input int at, input logic conf, input logic [3:0] mov,
                           input logic [2:0] x, input logic [2:0] y);
        ev_t e;
        e.at = at; e.conf = conf; e.mov = mov; e.x = x; e.y = y;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input logic [2:0] ex, input logic [2:0] ey);
        check("rst_confirm_pulse", 32'(bus.confirm_pulse), 32'd0);
        check("rst_mov_pulse", 32'(bus.mov_pulse), 32'd0);
        check("rst_cur_x", 32'(bus.cur_x), 32'(ex));
        check("rst_cur_y", 32'(bus.cur_y), 32'(ey));
    endtask

    // One short press (released before any auto-repeat) of the given keys.
    task automatic press_step(input logic [3:0] mask, input logic conf, input logic en,
                              input logic [2:0] ex, input logic [2:0] ey);
        bus.cursor_en     = en;
        bus.btn_mov_n     = ~mask;
        bus.btn_confirm_n = ~conf;
        push_ev(cyc + c_db + 3, conf, mask, ex, ey);
        wait_cyc(8);
        bus.btn_mov_n     = 4'hF;
        bus.btn_confirm_n = 1'b1;
        wait_cyc(12);
    endtask

    // Scoreboard: every pulse must match the head of the expected queue,
    // and the cursor is compared in the following cycle.
    always @(negedge clk) begin
        ev_t e;
        if (chk_cur) begin
            check("cur_x", 32'(bus.cur_x), 32'(exp_cx));
            check("cur_y", 32'(bus.cur_y), 32'(exp_cy));
            chk_cur = 1'b0;
        end
        if ((bus.confirm_pulse === 1'b1) || ((|bus.mov_pulse) === 1'b1)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got confirm=%b mov=%b at cycle %0d, expected none",
                         bus.confirm_pulse, bus.mov_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.at));
                check("confirm_pulse", 32'(bus.confirm_pulse), 32'(e.conf));
                check("mov_pulse", 32'(bus.mov_pulse), 32'(e.mov));
                exp_cx  = e.x;
                exp_cy  = e.y;
                chk_cur = 1'b1;
            end
        end
    end

    initial begin
        vec_t tbl [16];
        int   c1;
        int   p;
        int   f;
        int   t;
        int   n;
        logic [2:0] xv;

        tbl[0]  = '{4'b0001, 1'b0, 1'b1, 3'd0, 3'd0};
        tbl[1]  = '{4'b0100, 1'b0, 1'b1, 3'd0, 3'd0};
        tbl[2]  = '{4'b0010, 1'b0, 1'b1, 3'd0, 3'd1};
        tbl[3]  = '{4'b0010, 1'b0, 1'b1, 3'd0, 3'd2};
        tbl[4]  = '{4'b0010, 1'b0, 1'b1, 3'd0, 3'd3};
        tbl[5]  = '{4'b0010, 1'b0, 1'b1, 3'd0, 3'd4};
        tbl[6]  = '{4'b0010, 1'b0, 1'b1, 3'd0, 3'd4};
        tbl[7]  = '{4'b0010, 1'b0, 1'b1, 3'd0, 3'd4};
        tbl[8]  = '{4'b0011, 1'b0, 1'b1, 3'd0, 3'd4};
        tbl[9]  = '{4'b0001, 1'b0, 1'b1, 3'd0, 3'd3};
        tbl[10] = '{4'b1010, 1'b0, 1'b1, 3'd1, 3'd4};
        tbl[11] = '{4'b1000, 1'b0, 1'b0, 3'd1, 3'd4};
        tbl[12] = '{4'b1000, 1'b0, 1'b1, 3'd2, 3'd4};
        tbl[13] = '{4'b0000, 1'b1, 1'b1, 3'd2, 3'd4};
        tbl[14] = '{4'b1100, 1'b0, 1'b1, 3'd2, 3'd4};
        tbl[15] = '{4'b0101, 1'b0, 1'b1, 3'd1, 3'd3};

        bus.btn_confirm_n = 1'b1;
        bus.btn_mov_n     = 4'hF;
        bus.cursor_en     = 1'b1;

        wait_cyc(2);
        reset = 1'b0;
        check_idle_outputs(3'd0, 3'd0);

        // Confirm sampled low at edge 10, held 50 cycles: single pulse, no repeat.
        while (cyc < 9) @(negedge clk);
        bus.btn_confirm_n = 1'b0;
        push_ev(16, 1'b1, 4'b0000, 3'd0, 3'd0);
        wait_cyc(50);
        bus.btn_confirm_n = 1'b1;
        wait_cyc(15);
        check("queue_drained_confirm", 32'(exp_q.size()), 32'd0);

        // Bouncy right key, then a long hold with auto-repeat into saturation.
        bus.btn_mov_n = 4'b0111;
        wait_cyc(3);
        bus.btn_mov_n = 4'hF;
        wait_cyc(2);
        bus.btn_mov_n = 4'b0111;
        c1 = cyc;
        p  = c1 + c_db + 3;
        f  = c1 + 60 + c_db + 2;
        xv = 3'd1;
        push_ev(p, 1'b0, 4'b1000, xv, 3'd0);
        t = p + c_dly;
        while (t < f) begin
            if (xv != 3'(c_grid - 1)) xv = xv + 3'd1;
            push_ev(t, 1'b0, 4'b1000, xv, 3'd0);
            t = t + c_rate;
        end
        n = exp_q.size();
        check("repeat_count", 32'(n), 32'd6);
        wait_cyc(60);
        bus.btn_mov_n = 4'hF;
        wait_cyc(15);
        check("queue_drained_repeat", 32'(exp_q.size()), 32'd0);

        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check_idle_outputs(3'd0, 3'd0);

        for (int i = 0; i < 16; i++) begin
            press_step(tbl[i].mask, tbl[i].conf, tbl[i].en, tbl[i].ex, tbl[i].ey);
        end
        check("queue_drained_table", 32'(exp_q.size()), 32'd0);

        // Move to (3,2), hold left into REPEAT, then pulse reset.
        press_step(4'b1000, 1'b0, 1'b1, 3'd2, 3'd3);
        press_step(4'b1000, 1'b0, 1'b1, 3'd3, 3'd3);
        press_step(4'b0001, 1'b0, 1'b1, 3'd3, 3'd2);
        bus.btn_mov_n = 4'b1011;
        p = cyc + c_db + 3;
        push_ev(p, 1'b0, 4'b0100, 3'd2, 3'd2);
        push_ev(p + c_dly, 1'b0, 4'b0100, 3'd1, 3'd2);
        while (cyc < p + c_dly + 2) @(negedge clk);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check_idle_outputs(3'd0, 3'd0);
        push_ev(cyc + c_db + 3, 1'b0, 4'b0100, 3'd0, 3'd0);
        wait_cyc(c_db + 5);
        bus.btn_mov_n = 4'hF;
        wait_cyc(15);
        check("queue_drained_reset", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
